// File: rtl/register_file.sv
// Architectural register file with per-register ROB rename tags; x0 is hardwired to zero.
// Optional macro REGFILE_COMMIT_BYPASS_EN forwards the committing value to same-cycle queries.
module register_file #(
    parameter int ROB_SIZE_BIT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic [4:0]              rf_set_idx,
    input  logic [ROB_SIZE_BIT-1:0] rf_set_dep,
    input  logic [4:0]              rob_set_idx,
    input  logic [31:0]             rob_set_reg_val,
    input  logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
    input  logic [4:0]              query_idx1,
    input  logic [4:0]              query_idx2,
    output logic [31:0]             query_val1,
    output logic [31:0]             query_val2,
    output logic                    query_has_dep1,
    output logic                    query_has_dep2,
    output logic [ROB_SIZE_BIT-1:0] query_dep1,
    output logic [ROB_SIZE_BIT-1:0] query_dep2
);

    logic [31:0]             val  [32];
    logic                    busy [32];
    logic [ROB_SIZE_BIT-1:0] dep  [32];

    // Rename is applied after commit so a same-cycle rename overrides the commit's busy clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                val[i]  <= '0;
                busy[i] <= 1'b0;
                dep[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (rob_set_idx != '0) begin
                val[rob_set_idx] <= rob_set_reg_val;
                if (dep[rob_set_idx] == rob_set_recorder) begin
                    busy[rob_set_idx] <= 1'b0;
                end
            end
            if (clear) begin
                for (int i = 0; i < 32; i++) begin
                    busy[i] <= 1'b0;
                    dep[i]  <= '0;
                end
            end else if (rf_set_idx != '0) begin
                busy[rf_set_idx] <= 1'b1;
                dep[rf_set_idx]  <= rf_set_dep;
            end
        end
    end

    logic bypass1;
    logic bypass2;

    always_comb begin
        bypass1 = 1'b0;
        bypass2 = 1'b0;
`ifdef REGFILE_COMMIT_BYPASS_EN
        bypass1 = (query_idx1 != '0) && (query_idx1 == rob_set_idx) &&
                  busy[query_idx1] && (dep[query_idx1] == rob_set_recorder);
        bypass2 = (query_idx2 != '0) && (query_idx2 == rob_set_idx) &&
                  busy[query_idx2] && (dep[query_idx2] == rob_set_recorder);
`endif
    end

    // Tags are masked by busy so a retired register reports dep 0.
    always_comb begin
        query_val1     = '0;
        query_has_dep1 = 1'b0;
        query_dep1     = '0;
        if (query_idx1 != '0) begin
            if (bypass1) begin
                query_val1 = rob_set_reg_val;
            end else begin
                query_val1     = val[query_idx1];
                query_has_dep1 = busy[query_idx1];
                query_dep1     = busy[query_idx1] ? dep[query_idx1] : '0;
            end
        end
    end

    always_comb begin
        query_val2     = '0;
        query_has_dep2 = 1'b0;
        query_dep2     = '0;
        if (query_idx2 != '0) begin
            if (bypass2) begin
                query_val2 = rob_set_reg_val;
            end else begin
                query_val2     = val[query_idx2];
                query_has_dep2 = busy[query_idx2];
                query_dep2     = busy[query_idx2] ? dep[query_idx2] : '0;
            end
        end
    end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file with per-register rename tags. It sits downstream of the reorder buffer's commit port and beside the decoder's issue logic. The decoder reads operand values or ROB dependency tags and marks a destination register as pending on a ROB entry. The ROB then retires results into the file in program order. On a branch-mispredict clear, all pending tags are dropped, and the committed values become the sole architectural state.

## Interface
Parameters:
- `ROB_SIZE_BIT`, default 4 (from config.v): width of a ROB index.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; synchronous, active-high.
- `rdy_in`  in  1  global ready; state frozen when low.
- `clear`  in  1  ROB flush (mispredict).
- `rf_set_idx`  in  5  destination register being renamed by the issuing instruction; 0 = no rename.
- `rf_set_dep`  in  `ROB_SIZE_BIT`  ROB index that will produce `rf_set_idx`.
- `rob_set_idx`  in  5  register committed by ROB this cycle; 0 = no commit.
- `rob_set_reg_val`  in  32  committed value.
- `rob_set_recorder`  in  `ROB_SIZE_BIT`  ROB index of the committing entry.
- `query_idx1`, `query_idx2`  in  5  source registers read by the decoder.
- `query_val1`, `query_val2`  out  32  register value.
- `query_has_dep1`, `query_has_dep2`  out  1  register is pending on a ROB entry.
- `query_dep1`, `query_dep2`  out  `ROB_SIZE_BIT`  ROB index being waited on; 0 when there is no dependency.

## Operation
- State consists of `val[1..31]` (32 b), `busy[1..31]`, and `dep[1..31]`. x0 is hardwired: it reads 0 with no dependency, and all writes and renames to it are ignored.
- Commit, when `rob_set_idx != 0`:
  - `val[rob_set_idx] <= rob_set_reg_val`.
  - `busy` is cleared only if `dep[rob_set_idx] == rob_set_recorder`. An older commit never clears a younger rename.
- Rename, when `rf_set_idx != 0`: `busy[rf_set_idx] <= 1` and `dep[rf_set_idx] <= rf_set_dep`.
- Rename and commit to the same register in the same cycle:
  - The value is written.
  - The rename wins: busy stays 1 and dep takes the new tag, even when the recorder matched the old tag.
- `clear && rdy_in`:
  - All `busy` bits and `dep` fields are zeroed.
  - Any rename in that cycle is discarded.
  - A commit in that cycle is still written to `val`, because the ROB asserts the flush one cycle after the branch commit and commits nothing in the flush cycle.
- `rdy_in` low: no state changes. Query outputs remain combinational on the held state.
- Queries are combinational. They return the state as it stood before this cycle's rename. An instruction reading and writing the same register (e.g. `add x5,x5,x1`) sees the old tag for its source.

## Timing
- Reset (`rst_in` high at a posedge) zeroes all `val`, `busy` and `dep`. After reset, every query outputs `val=0`, `has_dep=0`, `dep=0`.
- Reset overrides `clear`, rename and commit in the same cycle.
- Write latency is 1 cycle: a commit or rename at edge N is visible on query outputs after edge N, within the same cycle.
- Query latency is 0 cycles (pure combinational read).
- There is no handshake. The ROB guarantees at most one commit per cycle, and the decoder guarantees at most one rename per cycle.

## Configuration
- `REGFILE_COMMIT_BYPASS_EN`
  - Defined: when a query hits the register committing this cycle and `busy && dep == rob_set_recorder`, the query returns `rob_set_reg_val` with `has_dep=0`. This saves the decoder one cycle of waiting on a retiring producer.
  - Undefined: queries reflect registered state only. The decoder relies on the ROB's own ready/value query to resolve the committing entry.
  - Committed state is identical in both builds.

## Test plan
- Reset, then query x0 and x7 → both return val=0, has_dep=0, dep=0. Then rename x0 with dep=3 → x0 still has has_dep=0.
- Rename x5 to dep=2. Next cycle query x5 → has_dep=1, dep=2. Commit x5=0xDEADBEEF with recorder=2. Next cycle query → val=0xDEADBEEF, has_dep=0.
- Rename x5 dep=2, then rename x5 dep=6. Commit x5=0x11 with recorder=2 → val=0x11, has_dep=1, dep=6. Commit x5=0x22 with recorder=6 → val=0x22, has_dep=0.
- In one cycle, rename x9 dep=4 and commit x9=0x55 with recorder=1, where x9 was busy on dep 1 → next cycle val=0x55, has_dep=1, dep=4.
- Rename x3 dep=1 and x4 dep=2 in consecutive cycles. Assert clear with a rename of x6 dep=3 in the same cycle → x3, x4 and x6 all have has_dep=0, and their values are unchanged. Holding `rdy_in`=0 during any commit leaves state unchanged.
- With `REGFILE_COMMIT_BYPASS_EN`, x8 busy on dep 5 and commit x8=0x1234 with recorder=5 → the same-cycle query returns 0x1234 with has_dep=0. Without the macro, the same-cycle query returns the old value with has_dep=1, dep=5.
